servo_step_sequencer: RTL and testbench
=======================================

# servo_step_sequencer

Frame-synchronous position sequencer for the servo PWM generator. Holds a small table of pulse-width/dwell steps. On a synchronized trigger edge it walks the table and presents one width per step to the PWM generator. Width changes happen only on PWM frame boundaries (`frame_tick`), so a pulse is never cut mid-period. It sits between the control logic/trigger input and the PWM generator's compare-value input.

## Interface
- `NSTEP`, 4: number of table steps (2..16).
- `WW`, 20: width field bits, in clock counts.
- `DW`, 8: dwell field bits, in PWM frames.
- `HOME_WIDTH`, 125000: home/reset pulse width (2.5 ms at 50 MHz).
- `MIN_WIDTH`, 25000: write clamp floor.
- `MAX_WIDTH`, 125000: write clamp ceiling.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `trig` in 1: asynchronous start request; sequence starts on its rising edge.
- `abort` in 1: synchronous level; return to home width.
- `frame_tick` in 1: one-cycle pulse from the PWM generator at period start.
- `wr_en` in 1: table write strobe.
- `wr_addr` in clog2(NSTEP): table index.
- `wr_width` in WW: step pulse width.
- `wr_dwell` in DW: step dwell in frames.
- `wr_rej` out 1: one-cycle pulse when a write is dropped.
- `width_out` out WW: width command to the PWM generator (registered).
- `width_vld` out 1: one-cycle pulse when `width_out` is loaded.
- `step_idx` out clog2(NSTEP): current step.
- `busy` out 1: high in ARM, RUN and HOME.
- `done` out 1: one-cycle pulse at sequence completion.

## Operation
- **Trigger sync:** `trig` passes through two flops s0→s1, then an edge flop s2. `pos = s1 & ~s2`.
- **Table writes:**
  - Accepted only in IDLE or DONE.
  - Width is clamped to [MIN_WIDTH, MAX_WIDTH].
  - A dwell of 0 is stored as 1.
  - A write in any other state is dropped and `wr_rej` pulses the next cycle.
- **States:** IDLE, ARM, RUN, HOME, DONE.
  - IDLE: `pos` → ARM. `abort` → HOME.
  - ARM, on `frame_tick`:
    - `width_out` ← table[0].width.
    - `width_vld` pulses.
    - `step_idx` ← 0.
    - dwell_cnt ← dwell−1.
    - Next state: RUN.
  - RUN, on `frame_tick`:
    - If dwell_cnt≠0: decrement dwell_cnt.
    - Else if `step_idx` < NSTEP−1: increment `step_idx`, load that step's width, pulse `width_vld`, reload dwell_cnt.
    - Else (last step): go to DONE.
  - DONE: `done` pulses for one cycle, `width_out` holds the last width, next state is IDLE.
  - HOME, on `frame_tick`: `width_out` ← HOME_WIDTH, `width_vld` pulses, `step_idx` ← 0, next state is IDLE. `done` is not asserted.
- **Priority per cycle:** `abort` > `pos` > `frame_tick`.
  - `pos` in ARM or RUN restarts: go to ARM, reset `step_idx` to 0, keep `width_out`.
  - `pos` in HOME or DONE is ignored.
  - `abort` in HOME is a no-op.
- **Widths:** `width_out` changes only in the cycle after a `frame_tick`.

## Timing
- **Reset values:**
  - state IDLE.
  - `width_out` = HOME_WIDTH.
  - `width_vld`, `done`, `wr_rej`, `busy` = 0.
  - `step_idx` = 0.
  - sync flops = 0.
  - Every table entry = {HOME_WIDTH, 1}.
- **Trigger latency:** `trig` rising before edge k makes `pos` high during cycle k+1. ARM is entered at edge k+2.
- **Load latency:** with `frame_tick` high in cycle n, `width_out`, `width_vld` and `step_idx` update at edge n+1. `done` likewise.
- **Step duration:** each step occupies exactly its dwell in frames. Total run = Σdwell frames after the first load.
- **Same-cycle events:**
  - `pos` with `frame_tick` in IDLE enters ARM only; the first load waits for the next tick.
  - `pos` with `frame_tick` in RUN restarts; no load happens that tick.
- **Reset mid-run:** asynchronous return to reset values. The table is also reinitialized.

## Configuration
- `SEQ_LOOP_EN` defined: at the last step's final tick, the sequencer loads step 0 (`width_vld` pulses) and stays in RUN. DONE is never reached, `done` never pulses, and only `abort` or `rst_n` stops it.
- `SEQ_LOOP_EN` undefined: behaviour as in Operation; the sequence ends in DONE.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN. Require `width_out`=125000, `busy`=0, `step_idx`=0, and table reads back as {125000, 1}.
- **Basic sequence:** write {107500,2}, {55000,1}, {25000,3}, {90000,1}, then pulse `trig`, with `frame_tick` every 1,000,000 clk.
  - Require loads of 107500, 55000, 25000, 90000 at ticks 1, 3, 4, 7.
  - Require `done` at tick 8 and `width_out` holding 90000.
- **Clamp and zero dwell:** write {200000,0} to step 0. Require the stored value to be {125000,1}. Write {1000,5}; require {25000,5}.
- **Abort mid-RUN at step 2:** require `width_out`=125000 at the next tick, `done` never asserted, and state IDLE.
- **Retrigger:** `trig` during step 1, with `pos` coinciding with `frame_tick`. Require no load on that tick, step 0 reloaded on the following tick, and a write attempted during RUN to produce `wr_rej`.
- **SEQ_LOOP_EN build:** run the basic-sequence table. Require step 0 to reload at tick 8, no `done` pulse, and `abort` to terminate at HOME_WIDTH.

Source files
------------

// File: rtl/servo_step_sequencer.sv
// ---------------------------------------------------------------------------
// servo_step_sequencer
//
// Frame-synchronous position sequencer for the servo PWM generator. Holds a
// table of NSTEP {pulse width, dwell} steps. A rising edge on the asynchronous
// trig input starts a walk through the table. Each step's width is handed to
// the PWM generator's compare input. New widths are only loaded on a PWM
// frame boundary (frame_tick), so a pulse is never cut mid-period.
//
// Optional feature macro: SEQ_LOOP_EN
//   defined   - after the last step the sequence wraps to step 0 and keeps
//               running until abort or reset.
//   undefined - the sequence ends in DONE and pulses done.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   trig         asynchronous start request (rising edge, synchronised here)
//   abort        synchronous level, return to HOME_WIDTH on the next frame
//   frame_tick   one-cycle pulse from the PWM generator at period start
//   wr_en        table write strobe (accepted in IDLE or DONE only)
//   wr_addr      table index
//   wr_width     step pulse width in clocks (clamped to MIN..MAX_WIDTH)
//   wr_dwell     step dwell in frames (0 is stored as 1)
//   wr_rej       one-cycle pulse, the cycle after a dropped write
//   width_out    registered width command to the PWM generator
//   width_vld    one-cycle pulse when width_out is loaded
//   step_idx     current step
//   busy         high in ARM, RUN and HOME
//   done         one-cycle pulse at sequence completion
// ---------------------------------------------------------------------------
module servo_step_sequencer #(
    parameter int NSTEP      = 4,
    parameter int WW         = 20,
    parameter int DW         = 8,
    parameter int HOME_WIDTH = 125000,
    parameter int MIN_WIDTH  = 25000,
    parameter int MAX_WIDTH  = 125000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trig,
    input  logic                     abort,
    input  logic                     frame_tick,
    input  logic                     wr_en,
    input  logic [$clog2(NSTEP)-1:0] wr_addr,
    input  logic [WW-1:0]            wr_width,
    input  logic [DW-1:0]            wr_dwell,
    output logic                     wr_rej,
    output logic [WW-1:0]            width_out,
    output logic                     width_vld,
    output logic [$clog2(NSTEP)-1:0] step_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(NSTEP);
    localparam logic [WW-1:0] HOME_W   = WW'(HOME_WIDTH);
    localparam logic [WW-1:0] MIN_W    = WW'(MIN_WIDTH);
    localparam logic [WW-1:0] MAX_W    = WW'(MAX_WIDTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(NSTEP - 1);

    typedef enum logic [2:0] {IDLE, ARM, RUN, HOME, DONE} state_t;

    state_t          state, state_nxt;
    logic            trig_s0, trig_s1, trig_s2;
    logic            pos;
    logic [WW-1:0]   tbl_width [NSTEP];
    logic [DW-1:0]   tbl_dwell [NSTEP];
    logic [DW-1:0]   dwell_cnt, cnt_nxt;
    logic [WW-1:0]   width_nxt, wr_width_clamped;
    logic [AW-1:0]   idx_nxt, idx_inc;
    logic            vld_nxt, done_nxt;
    logic            wr_ok;

    // Two-flop synchroniser plus an edge flop; pos is the rising edge of trig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s0 <= 1'b0;
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
        end else begin
            trig_s0 <= trig;
            trig_s1 <= trig_s0;
            trig_s2 <= trig_s1;
        end
    end

    assign pos = trig_s1 & ~trig_s2;

    // The table may only change while no sequence is reading it.
    assign wr_ok = wr_en && (state == IDLE || state == DONE);

    always_comb begin
        wr_width_clamped = wr_width;
        if (wr_width < MIN_W) begin
            wr_width_clamped = MIN_W;
        end else if (wr_width > MAX_W) begin
            wr_width_clamped = MAX_W;
        end
    end

    // The table is part of the reset domain, so a reset always restores a
    // harmless all-home profile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTEP; i++) begin
                tbl_width[i] <= HOME_W;
                tbl_dwell[i] <= DW'(1);
            end
            wr_rej <= 1'b0;
        end else begin
            wr_rej <= wr_en & ~wr_ok;
            if (wr_ok) begin
                tbl_width[wr_addr] <= wr_width_clamped;
                tbl_dwell[wr_addr] <= (wr_dwell == '0) ? DW'(1) : wr_dwell;
            end
        end
    end

    assign idx_inc = step_idx + AW'(1);

    // Next-state and datapath. Priority inside each state: abort, then pos,
    // then frame_tick. A restart keeps the current width on the output so the
    // servo does not jump until the next frame loads step 0.
    always_comb begin
        state_nxt = state;
        width_nxt = width_out;
        vld_nxt   = 1'b0;
        idx_nxt   = step_idx;
        cnt_nxt   = dwell_cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (abort) begin
                    state_nxt = HOME;
                end else if (pos) begin
                    state_nxt = ARM;
                end
            end
            ARM, RUN: begin
                if (abort) begin
                    state_nxt = HOME;
                end else if (pos) begin
                    state_nxt = ARM;
                    idx_nxt   = '0;
                end else if (frame_tick) begin
                    if (state == ARM) begin
                        state_nxt = RUN;
                        width_nxt = tbl_width[0];
                        vld_nxt   = 1'b1;
                        idx_nxt   = '0;
                        cnt_nxt   = tbl_dwell[0] - DW'(1);
                    end else if (dwell_cnt != '0) begin
                        cnt_nxt = dwell_cnt - DW'(1);
                    end else if (step_idx < LAST_IDX) begin
                        width_nxt = tbl_width[idx_inc];
                        vld_nxt   = 1'b1;
                        idx_nxt   = idx_inc;
                        cnt_nxt   = tbl_dwell[idx_inc] - DW'(1);
                    end else begin
`ifdef SEQ_LOOP_EN
                        width_nxt = tbl_width[0];
                        vld_nxt   = 1'b1;
                        idx_nxt   = '0;
                        cnt_nxt   = tbl_dwell[0] - DW'(1);
`else
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
`endif
                    end
                end
            end
            HOME: begin
                if (frame_tick) begin
                    state_nxt = IDLE;
                    width_nxt = HOME_W;
                    vld_nxt   = 1'b1;
                    idx_nxt   = '0;
                end
            end
            DONE: begin
                state_nxt = abort ? HOME : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            width_out <= HOME_W;
            width_vld <= 1'b0;
            step_idx  <= '0;
            dwell_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            width_out <= width_nxt;
            width_vld <= vld_nxt;
            step_idx  <= idx_nxt;
            dwell_cnt <= cnt_nxt;
            done      <= done_nxt;
        end
    end

    assign busy = (state == ARM) || (state == RUN) || (state == HOME);

endmodule

// File: tb/tb_servo_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_servo_step_sequencer
//
// Directed bench for servo_step_sequencer. Frame ticks are issued by hand a
// few clocks apart. Every expected value is a hand-computed constant from
// the step table written at the top of each scenario. Follows SEQ_LOOP_EN
// when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_servo_step_sequencer;

    localparam int NSTEP = 4;
    localparam int WW    = 20;
    localparam int DW    = 8;
    localparam int AW    = 2;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          trig       = 1'b0;
    logic          abort      = 1'b0;
    logic          frame_tick = 1'b0;
    logic          wr_en      = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [WW-1:0] wr_width   = '0;
    logic [DW-1:0] wr_dwell   = '0;
    logic          wr_rej;
    logic [WW-1:0] width_out;
    logic          width_vld;
    logic [AW-1:0] step_idx;
    logic          busy;
    logic          done;

    int checks    = 0;
    int failures  = 0;
    int doneCount = 0;

    // Basic table {107500,2} {55000,1} {25000,3} {90000,1}: state after ticks 1..7
    int bW [7] = '{107500, 107500, 55000, 25000, 25000, 25000, 90000};
    int bV [7] = '{1, 0, 1, 1, 0, 0, 1};
    int bI [7] = '{0, 0, 1, 2, 2, 2, 3};

    servo_step_sequencer #(
        .NSTEP(NSTEP), .WW(WW), .DW(DW),
        .HOME_WIDTH(125000), .MIN_WIDTH(25000), .MAX_WIDTH(125000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort),
        .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_width(wr_width), .wr_dwell(wr_dwell), .wr_rej(wr_rej),
        .width_out(width_out), .width_vld(width_vld), .step_idx(step_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && done) doneCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkTick(input string tag, input int vld, input int w,
                             input int idx, input int dn, input int bsy);
        checkOutput({tag, "_vld"},  int'(width_vld), vld);
        checkOutput({tag, "_w"},    int'(width_out), w);
        checkOutput({tag, "_idx"},  int'(step_idx),  idx);
        checkOutput({tag, "_done"}, int'(done),      dn);
        checkOutput({tag, "_busy"}, int'(busy),      bsy);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame tick after a short gap; returns at the negedge after the tick
    // edge, where the loaded values are visible.
    task automatic applyStimulus();
        idleCycles(3);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic writeStep(input int addr, input int w, input int d,
                             input int expRej, input string tag);
        wr_en    = 1'b1;
        wr_addr  = AW'(addr);
        wr_width = WW'(w);
        wr_dwell = DW'(d);
        @(negedge clk);
        wr_en = 1'b0;
        checkOutput(tag, int'(wr_rej), expRej);
    endtask

    // trig set before edge k puts the FSM in ARM after edge k+2.
    task automatic pulseTrig(input string tag);
        trig = 1'b1;
        idleCycles(3);
        trig = 1'b0;
        checkOutput(tag, int'(busy), 1);
    endtask

    task automatic pulseAbort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic runBasic(input int first, input int last, input string tag);
        for (int t = first; t <= last; t++) begin
            applyStimulus();
            checkTick($sformatf("%s_t%0d", tag, t + 1), bV[t], bW[t], bI[t], 0, 1);
        end
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        idleCycles(2);
        checkTick("reset", 0, 125000, 0, 0, 0);
        checkOutput("reset_wr_rej", int'(wr_rej), 0);
        rst_n = 1'b1;
        idleCycles(2);

        // Basic sequence
        writeStep(0, 107500, 2, 0, "wr0_rej");
        writeStep(1, 55000,  1, 0, "wr1_rej");
        writeStep(2, 25000,  3, 0, "wr2_rej");
        writeStep(3, 90000,  1, 0, "wr3_rej");
        pulseTrig("basic_arm");
        runBasic(0, 6, "basic");
        applyStimulus();
`ifdef SEQ_LOOP_EN
        checkTick("basic_t8_loop", 1, 107500, 0, 0, 1);
        pulseAbort();
        applyStimulus();
        checkTick("basic_home", 1, 125000, 0, 0, 0);
`else
        checkTick("basic_t8", 0, 90000, 3, 1, 0);
        idleCycles(1);
        checkOutput("basic_done_clear", int'(done), 0);
        checkOutput("basic_w_hold", int'(width_out), 90000);
`endif

        // Clamp high and zero dwell
        writeStep(0, 200000, 0, 0, "wr_clamp_hi_rej");
        pulseTrig("clamp_hi_arm");
        applyStimulus();
        checkTick("clamp_hi_t1", 1, 125000, 0, 0, 1);
        applyStimulus();
        checkTick("clamp_hi_t2", 1, 55000, 1, 0, 1);
        pulseAbort();
        applyStimulus();
        checkTick("clamp_hi_home", 1, 125000, 0, 0, 0);

        // Clamp low with dwell 5
        writeStep(0, 1000, 5, 0, "wr_clamp_lo_rej");
        pulseTrig("clamp_lo_arm");
        applyStimulus();
        checkTick("clamp_lo_t1", 1, 25000, 0, 0, 1);
        for (int t = 2; t <= 5; t++) begin
            applyStimulus();
            checkTick($sformatf("clamp_lo_t%0d", t), 0, 25000, 0, 0, 1);
        end
        applyStimulus();
        checkTick("clamp_lo_t6", 1, 55000, 1, 0, 1);
        pulseAbort();
        applyStimulus();
        checkTick("clamp_lo_home", 1, 125000, 0, 0, 0);

        // Abort mid-RUN at step 2
        writeStep(0, 107500, 2, 0, "wr_restore_rej");
        pulseTrig("abort_arm");
        runBasic(0, 3, "abort");
        pulseAbort();
        checkOutput("abort_hold_w", int'(width_out), 25000);
        checkOutput("abort_home_busy", int'(busy), 1);
        applyStimulus();
        checkTick("abort_home", 1, 125000, 0, 0, 0);

        // Retrigger during step 1, pos coinciding with frame_tick
        pulseTrig("retrig_arm");
        runBasic(0, 2, "retrig");
        writeStep(2, 30000, 4, 1, "wr_rej_run");
        idleCycles(1);
        checkOutput("wr_rej_clear", int'(wr_rej), 0);
        trig = 1'b1;
        idleCycles(2);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        trig       = 1'b0;
        checkTick("retrig_coincide", 0, 55000, 0, 0, 1);
        applyStimulus();
        checkTick("retrig_r1", 1, 107500, 0, 0, 1);
        applyStimulus();
        checkTick("retrig_r2", 0, 107500, 0, 0, 1);
        applyStimulus();
        checkTick("retrig_r3", 1, 55000, 1, 0, 1);
        applyStimulus();
        checkTick("retrig_r4", 1, 25000, 2, 0, 1);

        // Reset mid-RUN, then the table must be back to {125000,1}
        rst_n = 1'b0;
        #1;
        checkTick("rst_run", 0, 125000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(1);
        pulseTrig("rst_arm");
        for (int t = 0; t < NSTEP; t++) begin
            applyStimulus();
            checkTick($sformatf("rst_t%0d", t + 1), 1, 125000, t, 0, 1);
        end
        applyStimulus();
`ifdef SEQ_LOOP_EN
        checkTick("rst_t5_loop", 1, 125000, 0, 0, 1);
        pulseAbort();
        applyStimulus();
        checkTick("rst_home", 1, 125000, 0, 0, 0);
        idleCycles(2);
        checkOutput("done_count", doneCount, 0);
`else
        checkTick("rst_t5", 0, 125000, 3, 1, 0);
        idleCycles(2);
        checkOutput("done_count", doneCount, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
